// File: rtl/opal_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : opal_pkg
//  Description : Shared types and constants for the OPAL receive sequencer:
//                sequencer state encoding, receiver state-watch encodings
//                and a small sizing helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package opal_pkg;

   // Sequencer FSM states; the encoding is exported on o_state.
   typedef enum logic [2:0] {
      SQ_IDLE    = 3'd0,
      SQ_ARM     = 3'd1,
      SQ_SETTLE  = 3'd2,
      SQ_CAPTURE = 3'd3,
      SQ_GAP     = 3'd4
   } seq_state_t;

   // Receiver state-watch encodings as reported on rx_state.
   localparam logic [3:0] RX_ST_IDLE = 4'd0;
   localparam logic [3:0] RX_ST_HIGH = 4'd1;
   localparam logic [3:0] RX_ST_LOW  = 4'd2;
   localparam logic [3:0] RX_ST_GET  = 4'd3;
   localparam logic [3:0] RX_ST_WAIT = 4'd4;
   localparam logic [3:0] RX_ST_FAIL = 4'd5;

   // Larger of two integers, used to size the shared ARM/GAP timer.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/opal_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : opal_sat_counter
//  Description : Up-counter that sticks at all-ones. A clear request wins
//                over a same-cycle increment.
//  Revision    : 1.0 - initial release
// ============================================================================
module opal_sat_counter
   import opal_pkg::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_inc,
   input  logic                 i_clr,
   output logic [CNT_WIDTH-1:0] o_cnt
);

   logic [CNT_WIDTH-1:0] cnt_d;
   logic [CNT_WIDTH-1:0] cnt_q;

   // Next count: clear first, otherwise increment unless already saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/opal_rx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : opal_rx_sequencer
//  Description : Drives the OPAL parallel receiver enable, detects frame
//                completion on the falling edge of rx_ready, snapshots all
//                variables into a shadow frame handed to one consumer via
//                valid/ack, and supervises timeouts and receiver faults.
//  Revision    : 1.0 - initial release
// ============================================================================
module opal_rx_sequencer
   import opal_pkg::*;
#(
   parameter int QTD_VARIABLES    = 16,
   parameter int OPAL_INPUT_WIDTH = 16,
   parameter int TIMEOUT_CYCLES   = 2000,
   parameter int GAP_CYCLES       = 8,
   parameter int CNT_WIDTH        = 16
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       i_start,
   input  logic                                       i_single,
   input  logic                                       i_stop,
   input  logic                                       i_clr,
   output logic                                       rx_enable,
   input  logic                                       rx_ready,
   input  logic [3:0]                                 rx_state,
   input  logic [QTD_VARIABLES*OPAL_INPUT_WIDTH-1:0]  rx_data,
   output logic [QTD_VARIABLES*OPAL_INPUT_WIDTH-1:0]  o_frame_data,
   output logic                                       o_frame_valid,
   input  logic                                       i_frame_ack,
   output logic [CNT_WIDTH-1:0]                       o_frame_cnt,
   output logic [CNT_WIDTH-1:0]                       o_err_cnt,
   output logic                                       o_overrun,
   output logic                                       o_busy,
   output logic [2:0]                                 o_state
);

   localparam int DATA_W  = QTD_VARIABLES * OPAL_INPUT_WIDTH;
   // One timer serves both the ARM timeout and the GAP hold-off.
   localparam int TMR_MAX = max_int(TIMEOUT_CYCLES, GAP_CYCLES);
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [TMR_W-1:0] C_TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0] C_GAP_LAST = TMR_W'(GAP_CYCLES - 1);

   seq_state_t          state_d, state_q;
   logic [TMR_W-1:0]    tmr_d, tmr_q;
   logic                cont_d, cont_q;
   logic                seen_d, seen_q;
   logic [DATA_W-1:0]   frame_d, frame_q;
   logic                valid_d, valid_q;
   logic                ovr_d, ovr_q;
   logic                frame_inc;
   logic                err_inc;

   // Next-state, timer, shadow frame and handshake logic.
   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      cont_d    = cont_q;
      frame_d   = frame_q;
      valid_d   = valid_q;
      ovr_d     = ovr_q;
      frame_inc = 1'b0;
      err_inc   = 1'b0;
      // rx_ready must be observed high before its fall counts as a frame end.
      seen_d    = (state_q == SQ_ARM) ? (seen_q | rx_ready) : 1'b0;

      // Stop only drops the continuous flag; start re-arms it while busy.
      if (i_stop) begin
         cont_d = 1'b0;
      end else if (i_start && (state_q != SQ_IDLE)) begin
         cont_d = 1'b1;
      end

      // The consumer's ack retires the frame unless a new capture lands now.
      if (valid_q && i_frame_ack && (state_q != SQ_CAPTURE)) begin
         valid_d = 1'b0;
      end

      case (state_q)
         SQ_IDLE: begin
            tmr_d = '0;
            if (i_start) begin
               cont_d  = 1'b1;
               state_d = SQ_ARM;
            end else if (i_single) begin
               cont_d  = 1'b0;
               state_d = SQ_ARM;
            end
         end

         SQ_ARM: begin
            tmr_d = tmr_q + TMR_W'(1);
            if ((rx_state == RX_ST_FAIL) || (tmr_q == C_TMO_LAST)) begin
               err_inc = 1'b1;
               tmr_d   = '0;
               state_d = SQ_GAP;
            end else if (seen_q && !rx_ready) begin
               tmr_d   = '0;
               state_d = SQ_SETTLE;
            end else if (i_stop && !seen_q && !rx_ready) begin
               // No frame in flight yet, so abandoning the attempt is safe.
               tmr_d   = '0;
               state_d = SQ_GAP;
            end
         end

         SQ_SETTLE: begin
            state_d = SQ_CAPTURE;
         end

         SQ_CAPTURE: begin
            frame_d   = rx_data;
            valid_d   = 1'b1;
            frame_inc = 1'b1;
            // Newest frame wins; flag the loss of an unconsumed one.
            if (valid_q && !i_frame_ack) begin
               ovr_d = 1'b1;
            end
            tmr_d   = '0;
            state_d = SQ_GAP;
         end

         SQ_GAP: begin
            if (tmr_q == C_GAP_LAST) begin
               tmr_d   = '0;
               state_d = cont_d ? SQ_ARM : SQ_IDLE;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end

         default: begin
            tmr_d   = '0;
            state_d = SQ_IDLE;
         end
      endcase

      // Clear beats a same-cycle overrun.
      if (i_clr) begin
         ovr_d = 1'b0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SQ_IDLE;
         tmr_q   <= '0;
         cont_q  <= 1'b0;
         seen_q  <= 1'b0;
         frame_q <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         cont_q  <= cont_d;
         seen_q  <= seen_d;
         frame_q <= frame_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   opal_sat_counter #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_frame_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_inc (frame_inc),
      .i_clr (i_clr),
      .o_cnt (o_frame_cnt)
   );

   opal_sat_counter #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_inc (err_inc),
      .i_clr (i_clr),
      .o_cnt (o_err_cnt)
   );

   // Enable stays high through SETTLE/CAPTURE so only GAP holds it low.
   assign rx_enable     = (state_q == SQ_ARM) || (state_q == SQ_SETTLE) ||
                          (state_q == SQ_CAPTURE);
   assign o_busy        = (state_q != SQ_IDLE);
   assign o_state       = state_q;
   assign o_frame_data  = frame_q;
   assign o_frame_valid = valid_q;
   assign o_overrun     = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_opal_rx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_opal_rx_sequencer
//  Description : Self-checking bench for opal_rx_sequencer with a receiver
//                model and a frame scoreboard. A second instance with a
//                4-bit counter shares all inputs to exercise saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_opal_rx_sequencer;
   import opal_pkg::*;

   localparam int NV = 16;
   localparam int W  = 16;
   localparam int DW = NV * W;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_start, i_single, i_stop, i_clr, i_frame_ack;
   logic          rx_ready;
   logic [3:0]    rx_state;
   logic [DW-1:0] rx_data;
   wire           rx_enable, o_frame_valid, o_overrun, o_busy;
   wire  [DW-1:0] o_frame_data;
   wire  [15:0]   o_frame_cnt, o_err_cnt;
   wire  [2:0]    o_state;
   wire           s_rx_enable, s_frame_valid, s_overrun, s_busy;
   wire  [DW-1:0] s_frame_data;
   wire  [3:0]    s_frame_cnt, s_err_cnt;
   wire  [2:0]    s_state;

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            mdl_mode = 0;      // 0 normal, 1 never ready, 2 fault
   bit            mdl_fixed = 1'b0;
   bit            auto_ack = 1'b0;
   bit            man_ack = 1'b0;
   bit            gap_chk = 1'b0;
   bit            gap_armed = 1'b0;
   bit            prev_en = 1'b0;
   int            low_run = 0;
   logic [15:0]   prev_cnt = '0;
   logic [DW-1:0] last_pushed = '0;
   logic [DW-1:0] sb_data[$];
   int            sb_cyc[$];

   opal_rx_sequencer dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_single(i_single),
      .i_stop(i_stop), .i_clr(i_clr), .rx_enable(rx_enable),
      .rx_ready(rx_ready), .rx_state(rx_state), .rx_data(rx_data),
      .o_frame_data(o_frame_data), .o_frame_valid(o_frame_valid),
      .i_frame_ack(i_frame_ack), .o_frame_cnt(o_frame_cnt),
      .o_err_cnt(o_err_cnt), .o_overrun(o_overrun), .o_busy(o_busy),
      .o_state(o_state)
   );

   opal_rx_sequencer #(.CNT_WIDTH(4)) dut_sat (
      .clk(clk), .rst(rst), .i_start(i_start), .i_single(i_single),
      .i_stop(i_stop), .i_clr(i_clr), .rx_enable(s_rx_enable),
      .rx_ready(rx_ready), .rx_state(rx_state), .rx_data(rx_data),
      .o_frame_data(s_frame_data), .o_frame_valid(s_frame_valid),
      .i_frame_ack(i_frame_ack), .o_frame_cnt(s_frame_cnt),
      .o_err_cnt(s_err_cnt), .o_overrun(s_overrun), .o_busy(s_busy),
      .o_state(s_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic pulse_start();  i_start  = 1'b1; @(negedge clk); i_start  = 1'b0; endtask
   task automatic pulse_single(); i_single = 1'b1; @(negedge clk); i_single = 1'b0; endtask
   task automatic pulse_stop();   i_stop   = 1'b1; @(negedge clk); i_stop   = 1'b0; endtask
   task automatic pulse_clr();    i_clr    = 1'b1; @(negedge clk); i_clr    = 1'b0; endtask

   task automatic wait_state(input string tag, input logic [2:0] s, input int maxc);
      int n = 0;
      while ((o_state !== s) && (n < maxc)) begin @(negedge clk); n++; end
      check_eq(tag, DW'(o_state), DW'(s));
   endtask

   task automatic wait_cnt(input string tag, input logic [15:0] c, input int maxc);
      int n = 0;
      while ((o_frame_cnt !== c) && (n < maxc)) begin @(negedge clk); n++; end
      check_eq(tag, DW'(o_frame_cnt), DW'(c));
   endtask

   // Receiver model: raise ready a few cycles after enable, then drop it with new vars.
   initial begin
      logic [DW-1:0] nd;
      rx_ready = 1'b0; rx_state = RX_ST_IDLE; rx_data = '0;
      forever begin
         @(negedge clk);
         if (rx_enable === 1'b1) begin
            if (mdl_mode == 2) begin
               rx_state = RX_ST_FAIL;
            end else if (mdl_mode == 0) begin
               rx_state = RX_ST_HIGH;
               repeat (3) @(negedge clk);
               rx_ready = 1'b1; rx_state = RX_ST_GET;
               for (int v = 0; v < NV; v++) nd[v*W +: W] = W'($urandom);
               if (mdl_fixed) begin nd[15:0] = 16'hA5A5; nd[DW-1 -: 16] = 16'h0001; end
               repeat (4) @(negedge clk);
               rx_data = nd; rx_ready = 1'b0; rx_state = RX_ST_WAIT;
               last_pushed = nd;
               sb_data.push_back(nd); sb_cyc.push_back(cyc);
            end
            while (rx_enable === 1'b1) @(negedge clk);
            rx_state = RX_ST_IDLE;
         end
      end
   end

   // Consumer: single-cycle acks, automatic or on demand.
   initial begin
      i_frame_ack = 1'b0;
      forever begin
         @(negedge clk); #1;
         i_frame_ack = man_ack || (auto_ack && o_frame_valid && !i_frame_ack);
      end
   end

   // Monitor: score each capture and measure enable-low gaps between frames.
   initial begin
      forever begin
         @(negedge clk);
         if (rx_enable && !prev_en) begin
            if (gap_chk && gap_armed) check_eq("gap_len", DW'(low_run), DW'(8));
            gap_armed = 1'b0;
            low_run = 0;
         end
         if (!rx_enable) low_run++;
         prev_en = rx_enable;
         if (o_frame_cnt == 16'(prev_cnt + 16'd1)) begin
            check_eq("sb_has_frame", DW'(sb_data.size() != 0), DW'(1));
            if (sb_data.size() != 0) begin
               check_eq("frame_data", o_frame_data, sb_data.pop_front());
               check_eq("latency", DW'(cyc - sb_cyc.pop_front()), DW'(3));
               check_eq("valid_on_cap", DW'(o_frame_valid), DW'(1));
            end
            if (gap_chk) gap_armed = 1'b1;
         end
         if (!gap_chk) gap_armed = 1'b0;
         prev_cnt = o_frame_cnt;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; i_start = 0; i_single = 0; i_stop = 0; i_clr = 0;
      repeat (3) @(negedge clk);
      check_eq("rst_enable", DW'(rx_enable), DW'(0));
      check_eq("rst_state", DW'(o_state), DW'(0));
      check_eq("rst_busy", DW'(o_busy), DW'(0));
      check_eq("rst_valid", DW'(o_frame_valid), DW'(0));
      check_eq("rst_data", o_frame_data, '0);
      check_eq("rst_fcnt", DW'(o_frame_cnt), DW'(0));
      rst = 1'b0;
      @(negedge clk);

      // Single frame with fixed lane values, then 8 GAP cycles back to idle.
      mdl_fixed = 1'b1;
      pulse_single();
      wait_state("t1_gap", SQ_GAP, 100);
      n = 0;
      while ((o_state === SQ_GAP) && (n < 50)) begin @(negedge clk); n++; end
      check_eq("t1_gap_cycles", DW'(n), DW'(8));
      check_eq("t1_idle", DW'(o_state), DW'(SQ_IDLE));
      check_eq("t1_fcnt", DW'(o_frame_cnt), DW'(1));
      check_eq("t1_var1", DW'(o_frame_data[15:0]), DW'(16'hA5A5));
      check_eq("t1_var16", DW'(o_frame_data[DW-1 -: 16]), DW'(16'h0001));
      mdl_fixed = 1'b0;

      // Continuous, five acked frames.
      pulse_clr();
      auto_ack = 1'b1; gap_chk = 1'b1;
      pulse_start();
      wait_cnt("t2_cnt", 16'd5, 500);
      pulse_stop();
      wait_state("t2_idle", SQ_IDLE, 100);
      gap_chk = 1'b0;
      check_eq("t2_fcnt", DW'(o_frame_cnt), DW'(5));
      check_eq("t2_ovr", DW'(o_overrun), DW'(0));

      // Continuous, two unacked frames.
      auto_ack = 1'b0;
      pulse_clr();
      pulse_start();
      wait_cnt("t3_cnt", 16'd2, 300);
      pulse_stop();
      wait_state("t3_idle", SQ_IDLE, 100);
      check_eq("t3_ovr", DW'(o_overrun), DW'(1));
      check_eq("t3_fcnt", DW'(o_frame_cnt), DW'(2));
      check_eq("t3_data", o_frame_data, last_pushed);

      // Timeout, then receiver fault.
      pulse_clr();
      check_eq("clr_ovr", DW'(o_overrun), DW'(0));
      mdl_mode = 1;
      pulse_single();
      n = 0;
      while (!rx_enable && (n < 20)) begin @(negedge clk); n++; end
      n = 0;
      while (rx_enable && (n < 3000)) begin @(negedge clk); n++; end
      check_eq("t4_tmo_len", DW'(n), DW'(2000));
      check_eq("t4_err1", DW'(o_err_cnt), DW'(1));
      wait_state("t4_idle1", SQ_IDLE, 50);
      mdl_mode = 2;
      pulse_single();
      @(negedge clk);
      wait_state("t4_idle2", SQ_IDLE, 100);
      check_eq("t4_err2", DW'(o_err_cnt), DW'(2));
      check_eq("t4_fcnt", DW'(o_frame_cnt), DW'(0));
      mdl_mode = 0;

      // Stop after ready seen still captures; ack coinciding with capture.
      pulse_start();
      n = 0;
      while (!rx_ready && (n < 50)) begin @(negedge clk); n++; end
      pulse_stop();
      wait_state("t5_cap", SQ_CAPTURE, 50);
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      check_eq("t5_valid", DW'(o_frame_valid), DW'(1));
      check_eq("t5_ovr", DW'(o_overrun), DW'(0));
      wait_state("t5_idle", SQ_IDLE, 50);
      check_eq("t5_fcnt", DW'(o_frame_cnt), DW'(1));

      // Reset while settling.
      pulse_single();
      wait_state("t6_settle", SQ_SETTLE, 50);
      rst = 1'b1;
      @(negedge clk);
      check_eq("t6_enable", DW'(rx_enable), DW'(0));
      check_eq("t6_valid", DW'(o_frame_valid), DW'(0));
      check_eq("t6_state", DW'(o_state), DW'(0));
      check_eq("t6_busy", DW'(o_busy), DW'(0));
      check_eq("t6_fcnt", DW'(o_frame_cnt), DW'(0));
      check_eq("t6_ecnt", DW'(o_err_cnt), DW'(0));
      check_eq("t6_ovr", DW'(o_overrun), DW'(0));
      check_eq("t6_data", o_frame_data, '0);
      rst = 1'b0;
      sb_data.delete(); sb_cyc.delete();
      @(negedge clk);

      // Seventeen frames: full-width counter vs 4-bit saturating counter.
      auto_ack = 1'b1;
      pulse_start();
      wait_cnt("t7_cnt", 16'd17, 1500);
      pulse_stop();
      wait_state("t7_idle", SQ_IDLE, 100);
      check_eq("t7_fcnt16", DW'(o_frame_cnt), DW'(17));
      check_eq("t7_fcnt4", DW'(s_frame_cnt), DW'(15));

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
